pe_bitserial_mac: RTL and testbench
===================================

Name: pe_bitserial_mac

Overview:
Next-generation processing-element controller and accumulator.
- Accepts a vector of multi-bit activations over a valid/ready handshake.
- Streams the activations bit-serially, LSB first, into an external SA array.
- Reduces the N_ROW_GRP row-group ADC results per column and shift-accumulates them over a runtime-selected precision.
- Supports optional two's-complement (signed) inputs.
- Presents full-precision per-column results on a valid/ready output; sits between the input activation buffer and the output/requant stage.

Parameters:
- N_ROWS, 1024, total PE input rows.
- N_COLS, 256, output columns.
- N_ROW_GRP, 4, row groups whose ADC outputs are summed per column (N_ROWS divisible by N_ROW_GRP).
- ADC_BITS, 4, SA ADC result width.
- MAX_IN_BITS, 8, maximum activation precision.
- PREC_W, $clog2(MAX_IN_BITS+1), width of precision field.
- SUM_BITS, ADC_BITS+$clog2(N_ROW_GRP), adder-tree output width.
- ACC_BITS, SUM_BITS+MAX_IN_BITS+1, signed accumulator width.

Ports:
- clk, input, 1, clock.
- nrst, input, 1, asynchronous active-low reset.
- in_valid_i, input, 1, activation vector valid.
- in_ready_o, output, 1, block can accept.
- in_data_i, input, [N_ROWS][MAX_IN_BITS], activations.
- in_prec_i, input, PREC_W, precision for this vector.
- in_signed_i, input, 1, 1 = two's-complement activations.
- sa_bits_o, output, N_ROWS, current bit plane to SA array.
- sa_start_o, output, 1, one-cycle SA conversion start.
- sa_done_i, input, 1, SA conversion complete.
- sa_data_i, input, [N_ROW_GRP][N_COLS][ADC_BITS], ADC results.
- out_valid_o, output, 1, result valid.
- out_ready_i, input, 1, downstream accepts.
- out_data_o, output, [N_COLS][ACC_BITS] signed, accumulated results.
- busy_o, output, 1, high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0 except in_ready_o = 1. Internal state: FSM IDLE, bit index k = 0, accumulators 0, buffers 0.
- FSM states: IDLE, ISSUE, WAIT, ACC, OUT.
- IDLE:
  - in_ready_o = 1 in IDLE only.
  - On in_valid_i && in_ready_o: register in_data_i, precision, signed flag; clear accumulators; k = 0; go to ISSUE.
  - Precision clamp: in_prec_i = 0 → 1; in_prec_i > MAX_IN_BITS → MAX_IN_BITS.
- ISSUE:
  - sa_bits_o[r] = bit k of row r.
  - sa_start_o = 1 for exactly this cycle.
  - Next state WAIT.
- WAIT:
  - sa_bits_o held stable.
  - On sa_done_i: register per-column sum over all N_ROW_GRP groups (unsigned, SUM_BITS wide, no truncation); go to ACC.
  - sa_done_i in any other state is ignored.
- ACC:
  - acc[c] += sum[c] << k.
  - Exception: when signed and k == prec-1, acc[c] -= sum[c] << k.
  - Then k++. If k == prec go to OUT, else go to ISSUE.
- OUT:
  - out_valid_o = 1; out_data_o = acc, held stable until out_ready_i.
  - On out_ready_i go to IDLE; out_valid_o drops the next cycle; out_data_o retains its last value.
- Latency: accept at cycle t, first sa_start_o at t+1. Per bit: 3 cycles + SA wait (sa_done_i the cycle after start gives 3 cycles/bit). out_valid_o first high at t+1+3*prec.
- in_valid_i while busy: not accepted; input must be held by the source.
- sa_bits_o returns to 0 outside ISSUE/WAIT.
- Reset mid-operation (any state): immediate return to reset values; partial result discarded; no sa_start_o after deassertion until a new accept.
- Arithmetic: ACC_BITS is sized so no overflow is possible for any in-range input; no saturation logic.

Decomposition:
- Shared package pe_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, ACC, OUT);
  - width helper constants/functions for SUM_BITS and ACC_BITS.
- One sub-module, pe_col_adder_tree: combinational per-column sum of N_ROW_GRP ADC values, parametrised on N_ROW_GRP, ADC_BITS, N_COLS.
- Instantiated once; its output is registered in WAIT.

Test Plan:
Config for all scenarios: N_ROW_GRP=4, ADC_BITS=4; SA stub asserts sa_done_i 2 cycles after sa_start_o.
- Unsigned, prec=4, stub returns 1 for every group/column each bit → out_data_o = 4*(1+2+4+8) = 60 on all columns; exactly 4 sa_start_o pulses.
- Signed, prec=4, same stub → out_data_o = 4*(1+2+4-8) = -4. Activation 0xF in row 0 → sa_bits_o[0] = 1 for all 4 bit planes.
- prec=0 → clamped to 1, single sa_start_o, result 4. prec=15 → clamped to 8 pulses, unsigned result 4*255 = 1020.
- Max values: ADC 15 everywhere, prec=8, unsigned → 60*255 = 15300. Signed → 60*(127-128) = -60.
- Backpressure: out_ready_i low 5 cycles → out_valid_o and out_data_o stable, in_ready_o = 0, in_valid_i ignored. Release → IDLE next cycle, new vector accepted.
- nrst pulsed during WAIT of bit 2 → all outputs at reset values, in_ready_o = 1. Later stray sa_done_i ignored. Following transaction yields the correct result.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and width helpers for the bit-serial processing element.
package pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACC,
    ST_OUT
  } pe_state_e;

  function automatic int sum_bits_f(input int adc_bits, input int n_row_grp);
    return adc_bits + $clog2(n_row_grp);
  endfunction

  function automatic int acc_bits_f(input int sum_bits, input int max_in_bits);
    return sum_bits + max_in_bits + 1;
  endfunction

endpackage

// File: rtl/pe_col_adder_tree.sv
// Per-column sum of the row-group ADC results (unsigned, full width).
module pe_col_adder_tree
  import pe_pkg::*;
#(
  parameter int N_ROW_GRP = 4,
  parameter int ADC_BITS  = 4,
  parameter int N_COLS    = 256,
  parameter int SUM_BITS  = sum_bits_f(ADC_BITS, N_ROW_GRP)
) (
  input  logic [N_ROW_GRP-1:0][N_COLS-1:0][ADC_BITS-1:0] i_adc,
  output logic [N_COLS-1:0][SUM_BITS-1:0]                o_sum
);

  always_comb begin
    o_sum = '0;
    for (int unsigned c = 0; c < N_COLS; c++) begin
      for (int unsigned g = 0; g < N_ROW_GRP; g++) begin
        o_sum[c] = o_sum[c] + SUM_BITS'(i_adc[g][c]);
      end
    end
  end

endmodule

// File: rtl/pe_bitserial_mac.sv
// Bit-serial PE controller: streams activation bit planes to the SA array and
// shift-accumulates the reduced per-column ADC results.
module pe_bitserial_mac
  import pe_pkg::*;
#(
  parameter int N_ROWS      = 1024,
  parameter int N_COLS      = 256,
  parameter int N_ROW_GRP   = 4,
  parameter int ADC_BITS    = 4,
  parameter int MAX_IN_BITS = 8,
  parameter int PREC_W      = $clog2(MAX_IN_BITS + 1),
  parameter int SUM_BITS    = sum_bits_f(ADC_BITS, N_ROW_GRP),
  parameter int ACC_BITS    = acc_bits_f(SUM_BITS, MAX_IN_BITS)
) (
  input  logic                                          clk,
  input  logic                                          nrst,
  input  logic                                          in_valid_i,
  output logic                                          in_ready_o,
  input  logic [N_ROWS-1:0][MAX_IN_BITS-1:0]            in_data_i,
  input  logic [PREC_W-1:0]                             in_prec_i,
  input  logic                                          in_signed_i,
  output logic [N_ROWS-1:0]                             sa_bits_o,
  output logic                                          sa_start_o,
  input  logic                                          sa_done_i,
  input  logic [N_ROW_GRP-1:0][N_COLS-1:0][ADC_BITS-1:0] sa_data_i,
  output logic                                          out_valid_o,
  input  logic                                          out_ready_i,
  output logic signed [N_COLS-1:0][ACC_BITS-1:0]        out_data_o,
  output logic                                          busy_o
);

  pe_state_e r_state, w_state_nxt;

  logic [N_ROWS-1:0][MAX_IN_BITS-1:0] r_data;
  logic [PREC_W-1:0]                  r_prec, r_k, w_prec_clamp, w_k_inc;
  logic                               r_signed;
  logic                               w_accept, w_last;
  logic [N_COLS-1:0][SUM_BITS-1:0]    w_sum, r_sum;
  logic signed [ACC_BITS-1:0]         r_acc  [N_COLS];
  logic signed [ACC_BITS-1:0]         w_term [N_COLS];

  pe_col_adder_tree #(
    .N_ROW_GRP (N_ROW_GRP),
    .ADC_BITS  (ADC_BITS),
    .N_COLS    (N_COLS),
    .SUM_BITS  (SUM_BITS)
  ) u_adder_tree (
    .i_adc (sa_data_i),
    .o_sum (w_sum)
  );

  assign w_accept = in_valid_i && (r_state == ST_IDLE);
  assign w_last   = (r_k == r_prec - PREC_W'(1));
  assign w_k_inc  = r_k + PREC_W'(1);

  always_comb begin
    w_prec_clamp = in_prec_i;
    if (in_prec_i == '0) begin
      w_prec_clamp = PREC_W'(1);
    end else if (in_prec_i > PREC_W'(MAX_IN_BITS)) begin
      w_prec_clamp = PREC_W'(MAX_IN_BITS);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    sa_start_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
        if (in_valid_i) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        sa_start_o  = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (sa_done_i) w_state_nxt = ST_ACC;
      end
      ST_ACC: begin
        w_state_nxt = (w_k_inc == r_prec) ? ST_OUT : ST_ISSUE;
      end
      ST_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit plane k is only driven while a conversion is being issued or awaited.
  always_comb begin
    sa_bits_o = '0;
    if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
      for (int unsigned r = 0; r < N_ROWS; r++) begin
        sa_bits_o[r] = 1'(r_data[r] >> r_k);
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < N_COLS; c++) begin
      w_term[c] = ACC_BITS'(r_sum[c]) << r_k;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_data   <= '0;
      r_prec   <= '0;
      r_k      <= '0;
      r_signed <= 1'b0;
      r_sum    <= '0;
      for (int unsigned c = 0; c < N_COLS; c++) begin
        r_acc[c] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_data   <= in_data_i;
        r_prec   <= w_prec_clamp;
        r_signed <= in_signed_i;
        r_k      <= '0;
        for (int unsigned c = 0; c < N_COLS; c++) begin
          r_acc[c] <= '0;
        end
      end
      if (r_state == ST_WAIT && sa_done_i) begin
        r_sum <= w_sum;
      end
      if (r_state == ST_ACC) begin
        // Two's-complement MSB plane carries negative weight.
        for (int unsigned c = 0; c < N_COLS; c++) begin
          r_acc[c] <= (r_signed && w_last) ? r_acc[c] - w_term[c]
                                           : r_acc[c] + w_term[c];
        end
        r_k <= w_k_inc;
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < N_COLS; c++) begin
      out_data_o[c] = r_acc[c];
    end
  end

endmodule

// File: tb/tb_pe_bitserial_mac.sv
// Self-checking bench for pe_bitserial_mac with an SA-array stub and an
// arithmetic reference model of the bit-serial weighted sum.
module tb_pe_bitserial_mac;

  localparam int NR  = 16;
  localparam int NC  = 4;
  localparam int NG  = 4;
  localparam int AB  = 4;
  localparam int MB  = 8;
  localparam int PW  = 4;
  localparam int ACW = 15;

  logic                          clk = 1'b0;
  logic                          nrst;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [NR-1:0][MB-1:0]         in_data_i;
  logic [PW-1:0]                 in_prec_i;
  logic                          in_signed_i;
  logic [NR-1:0]                 sa_bits_o;
  logic                          sa_start_o;
  logic                          sa_done_i;
  logic [NG-1:0][NC-1:0][AB-1:0] sa_data_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [NC-1:0][ACW-1:0]        out_data_o;
  logic                          busy_o;

  pe_bitserial_mac #(
    .N_ROWS      (NR),
    .N_COLS      (NC),
    .N_ROW_GRP   (NG),
    .ADC_BITS    (AB),
    .MAX_IN_BITS (MB)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_prec_i   (in_prec_i),
    .in_signed_i (in_signed_i),
    .sa_bits_o   (sa_bits_o),
    .sa_start_o  (sa_start_o),
    .sa_done_i   (sa_done_i),
    .sa_data_i   (sa_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_res [NC];
  bit chk_en   = 1'b1;
  int start_cnt = 0;
  int plane_idx = 0;
  int sa_lat    = 2;
  int stub_cnt  = 0;
  int adc_mode  = 0;
  int adc_cval  = 1;
  logic [MB-1:0] act [NR];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int adc_val(input int j, input int g, input int c);
    if (adc_mode == 0) return adc_cval;
    return (j * 3 + g * 5 + c * 7 + 1) % 16;
  endfunction

  function automatic logic [NR-1:0] plane(input int j);
    logic [NR-1:0] p;
    for (int r = 0; r < NR; r++) p[r] = act[r][j];
    return p;
  endfunction

  function automatic int col(input int c);
    logic signed [ACW-1:0] v;
    v = out_data_o[c];
    return int'(v);
  endfunction

  // SA stub plus per-cycle output comparison, all on the falling edge.
  initial begin
    sa_done_i = 1'b0;
    sa_data_i = '0;
    forever begin
      @(negedge clk);
      sa_done_i = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          sa_done_i = 1'b1;
          for (int g = 0; g < NG; g++)
            for (int c = 0; c < NC; c++)
              sa_data_i[g][c] = AB'(adc_val(plane_idx, g, c));
          plane_idx++;
          if (chk_en) check("sa_bits_wait", int'(sa_bits_o), int'(plane(start_cnt - 1)));
        end
      end
      if (sa_start_o) begin
        start_cnt++;
        stub_cnt = sa_lat;
        if (chk_en) check("sa_bits_issue", int'(sa_bits_o), int'(plane(start_cnt - 1)));
      end
      if (chk_en && in_ready_o) check("sa_bits_idle", int'(sa_bits_o), 0);
      if (chk_en && out_valid_o) begin
        check("in_ready_in_out", int'(in_ready_o), 0);
        for (int c = 0; c < NC; c++) check($sformatf("out_data[%0d]", c), col(c), exp_res[c]);
      end
    end
  end

  task automatic run_txn(input int prec_in, input bit sgn, input int mode, input int cval,
                         input int lat, input int bp, input int lit);
    int p, n, w, s;
    p = (prec_in == 0) ? 1 : (prec_in > MB) ? MB : prec_in;
    adc_mode = mode;
    adc_cval = cval;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int j = 0; j < p; j++) begin
        w = 1 << j;
        if (sgn && j == p - 1) w = -w;
        for (int g = 0; g < NG; g++) s += w * adc_val(j, g, c);
      end
      exp_res[c] = s;
    end
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", int'(in_ready_o), 1);
    sa_lat      = lat;
    start_cnt   = 0;
    plane_idx   = 0;
    in_valid_i  = 1'b1;
    for (int r = 0; r < NR; r++) in_data_i[r] = act[r];
    in_prec_i   = PW'(prec_in);
    in_signed_i = sgn;
    @(negedge clk);
    in_valid_i = 1'b0;
    check("busy_after_accept", int'(busy_o), 1);
    n = 1;
    while (!out_valid_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 1 + (lat + 2) * p);
    check("sa_start_pulses", start_cnt, p);
    check("lit_col0", col(0), lit);
    for (int i = 0; i < bp; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = '1;
      @(negedge clk);
      check("bp_valid_held", int'(out_valid_o), 1);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    check("valid_drop", int'(out_valid_o), 0);
    check("ready_back", int'(in_ready_o), 1);
    check("data_retained", col(0), lit);
    check("no_accept_during_bp", int'(busy_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, starts;
    nrst        = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_prec_i   = '0;
    in_signed_i = 1'b0;
    out_ready_i = 1'b0;
    act[0] = 8'h0F;
    for (int r = 1; r < NR; r++) act[r] = MB'((r * 37 + 5) & 8'hFF);
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_sa_start", int'(sa_start_o), 0);
    check("rst_out_valid", int'(out_valid_o), 0);
    check("rst_sa_bits", int'(sa_bits_o), 0);
    check("rst_out_data", col(0), 0);
    nrst = 1'b1;

    run_txn(4,  1'b0, 0, 1,  2, 0, 60);
    run_txn(4,  1'b1, 0, 1,  1, 0, -4);
    run_txn(0,  1'b0, 0, 1,  1, 0, 4);
    run_txn(15, 1'b0, 0, 1,  2, 0, 1020);
    run_txn(8,  1'b0, 0, 15, 1, 0, 15300);
    run_txn(8,  1'b1, 0, 15, 2, 0, -60);
    run_txn(6,  1'b1, 1, 0,  1, 5, 70);

    // Reset asserted while waiting on the conversion of bit plane 2.
    adc_mode = 0;
    adc_cval = 1;
    sa_lat   = 2;
    @(negedge clk);
    start_cnt   = 0;
    plane_idx   = 0;
    in_valid_i  = 1'b1;
    for (int r = 0; r < NR; r++) in_data_i[r] = act[r];
    in_prec_i   = PW'(4);
    in_signed_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    n = 0;
    while (!(start_cnt == 3 && !sa_start_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit2_wait", start_cnt, 3);
    chk_en = 1'b0;
    nrst   = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", int'(in_ready_o), 1);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_out_valid", int'(out_valid_o), 0);
    check("mid_rst_sa_bits", int'(sa_bits_o), 0);
    check("mid_rst_out_data", col(0), 0);
    nrst   = 1'b1;
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sa_start_o) starts++;
    end
    check("no_start_after_rst", starts, 0);
    check("idle_after_stray_done", int'(in_ready_o), 1);
    chk_en = 1'b1;
    run_txn(4, 1'b0, 0, 1, 2, 0, 60);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
